// File: rtl/edge_det_pkg.sv
// Shared types and mode encoding for the multi-channel edge detector.
// No latency: declarations and a pure combinational helper only.
// No backpressure: nothing in here carries flow control.
package edge_det_pkg;

    // Per-channel edge selection: bit 0 enables rising edges, bit 1 enables falling edges
    typedef logic [1:0] edge_mode_t;

    localparam edge_mode_t MODE_OFF  = 2'b00;
    localparam edge_mode_t MODE_RISE = 2'b01;
    localparam edge_mode_t MODE_FALL = 2'b10;
    localparam edge_mode_t MODE_BOTH = 2'b11;

    // True when a transition to new_level is a direction the mode asks us to report
    function automatic logic edge_allowed(edge_mode_t mode, logic new_level);
        logic allow;
        case (mode)
            MODE_RISE: allow = new_level;
            MODE_FALL: allow = ~new_level;
            MODE_BOTH: allow = 1'b1;
            default:   allow = 1'b0;
        endcase
        return allow;
    endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One channel: synchroniser, stable-count glitch filter, edge qualifier and sticky pending flag.
// Latency: data_in change to edge_pulse = SYNC_STAGES + filt_len + 1 rising edges, counting the sampling edge.
// No backpressure: pulses are never held off; pending absorbs them until cleared.
module edge_filter_ch
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_in,
    input  edge_mode_t        mode,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              clr,
    output logic              level_out,
    output logic              edge_pulse,
    output logic              pending,
    output logic              pending_nxt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [FILT_W-1:0]      cnt;
    logic [FILT_W-1:0]      cnt_nxt;
    logic                   level_nxt;
    logic                   pulse_nxt;

    // Stage 0 takes the raw pin; the highest stage is the metastability-safe copy
    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
        end
    end

    // Filter: the level only moves after filt_len+1 consecutive disagreeing samples.
    // cnt holds how many earlier consecutive cycles already disagreed, so it can
    // never pass filt_len and a shrinking filt_len releases the level at once.
    always_comb begin
        level_nxt = level_out;
        cnt_nxt   = '0;
        pulse_nxt = 1'b0;
        if (sync != level_out) begin
            if (cnt >= filt_len) begin
                level_nxt = sync;
                pulse_nxt = edge_allowed(mode, sync);
            end else begin
                cnt_nxt = cnt + FILT_W'(1);
            end
        end
    end

    // Sticky flag: a new pulse beats a simultaneous clear
    assign pending_nxt = edge_pulse | (pending & ~clr);

    // Filter, edge and pending state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            level_out  <= 1'b0;
            edge_pulse <= 1'b0;
            pending    <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            level_out  <= level_nxt;
            edge_pulse <= pulse_nxt;
            pending    <= pending_nxt;
        end
    end

endmodule

// File: rtl/edge_detector_multi.sv
// N_CH independent filtered edge detectors with sticky flags and one aggregated interrupt.
// Latency: SYNC_STAGES + filt_len + 1 edges to edge_pulse; pending and irq one edge later.
// No backpressure: every qualified edge pulses; pending holds it until write-1-to-clear.
module edge_detector_multi
    import edge_det_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [N_CH-1:0]     data_in,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic [N_CH-1:0]     clr,
    output logic [N_CH-1:0]     level_out,
    output logic [N_CH-1:0]     edge_pulse,
    output logic [N_CH-1:0]     pending,
    output logic                irq
);

    logic [N_CH-1:0] pending_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .data_in     (data_in[i]),
            .mode        (mode[2*i +: 2]),
            .filt_len    (filt_len),
            .clr         (clr[i]),
            .level_out   (level_out[i]),
            .edge_pulse  (edge_pulse[i]),
            .pending     (pending[i]),
            .pending_nxt (pending_nxt[i])
        );
    end

    // irq registers the OR of next-cycle pending so it rises and falls with pending
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq <= 1'b0;
        end else begin
            irq <= |pending_nxt;
        end
    end

endmodule

// File: tb/tb_edge_detector_multi.sv
module tb_edge_detector_multi;
    import edge_det_pkg::*;

    localparam int N_CH        = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_W      = 4;

    logic                clk = 1'b0;
    logic                resetn;
    logic [N_CH-1:0]     data_in;
    logic [2*N_CH-1:0]   mode;
    logic [FILT_W-1:0]   filt_len;
    logic [N_CH-1:0]     clr;
    logic [N_CH-1:0]     level_out;
    logic [N_CH-1:0]     edge_pulse;
    logic [N_CH-1:0]     pending;
    logic                irq;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: a level flips once the last filt_len+1 synchronised samples,
    // all taken after the previous flip, disagree with it.
    logic [N_CH-1:0] s_hist [0:4095];
    int              k;
    int              last_flip [N_CH];
    logic [N_CH-1:0] m_lvl, m_pulse, m_pend;
    logic            m_irq;
    logic [N_CH-1:0] pulse_acc;

    edge_detector_multi #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .mode       (mode),
        .filt_len   (filt_len),
        .clr        (clr),
        .level_out  (level_out),
        .edge_pulse (edge_pulse),
        .pending    (pending),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0t observed=0x%0h expected=0x%0h", tag, $time, obs, expv);
        end
    endtask

    function automatic logic seen(int idx, int ch);
        if (idx < SYNC_STAGES) return 1'b0;
        return s_hist[idx - SYNC_STAGES][ch];
    endfunction

    function automatic logic dir_enabled(logic [1:0] m, logic rising);
        return rising ? m[0] : m[1];
    endfunction

    task automatic model_reset();
        k = 0;
        for (int ch = 0; ch < N_CH; ch++) last_flip[ch] = -1;
        m_lvl = '0; m_pulse = '0; m_pend = '0; m_irq = 1'b0;
    endtask

    task automatic model_edge();
        logic [N_CH-1:0] nl, np, npend;
        logic flip;
        int idx;
        s_hist[k] = data_in;
        nl = m_lvl;
        np = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            flip = 1'b1;
            for (int j = 0; j <= int'(filt_len); j++) begin
                idx = k - j;
                if (idx < 0 || idx <= last_flip[ch] || seen(idx, ch) == m_lvl[ch]) flip = 1'b0;
            end
            if (flip) begin
                nl[ch] = ~m_lvl[ch];
                last_flip[ch] = k;
                np[ch] = dir_enabled(mode[2*ch +: 2], nl[ch]);
            end
        end
        npend   = m_pulse | (m_pend & ~clr);
        m_lvl   = nl;
        m_pulse = np;
        m_pend  = npend;
        m_irq   = |npend;
        k++;
    endtask

    task automatic step();
        @(posedge clk);
        if (resetn) model_edge();
        #1;
        chk("level_out", 32'(level_out), 32'(m_lvl));
        chk("edge_pulse", 32'(edge_pulse), 32'(m_pulse));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("irq", 32'(irq), 32'(m_irq));
        pulse_acc |= edge_pulse;
        @(negedge clk);
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        resetn = 1'b0; data_in = 8'hFF; mode = {8{MODE_RISE}}; filt_len = '0; clr = '0;
        pulse_acc = '0;
        model_reset();
        @(negedge clk);
        steps(2);
        chk("rst_level", 32'(level_out), 32'h0);
        chk("rst_pulse", 32'(edge_pulse), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // Input high through reset: one rising edge at the normal latency
        resetn = 1'b1;
        steps(2);
        chk("rst_no_early_pulse", 32'(edge_pulse), 32'h0);
        step();
        chk("rst_rise_pulse", 32'(edge_pulse), 32'hFF);
        step();
        chk("rst_pulse_width", 32'(edge_pulse), 32'h0);
        chk("rst_pending_set", 32'(pending), 32'hFF);
        chk("rst_irq_set", 32'(irq), 32'h1);
        clr = 8'hFF; data_in = 8'h00;
        steps(6);
        clr = '0;
        step();

        // Glitch shorter than filt_len+1 is rejected, 4-cycle pulse passes at 6 edges
        filt_len = 4'd3; mode = {8{MODE_BOTH}}; pulse_acc = '0;
        data_in[0] = 1'b1; steps(3);
        data_in[0] = 1'b0; steps(10);
        chk("glitch_no_pulse", 32'(pulse_acc[0]), 32'h0);
        chk("glitch_level", 32'(level_out[0]), 32'h0);
        data_in[0] = 1'b1; steps(4);
        data_in[0] = 1'b0; step();
        chk("filt_no_pulse_at5", 32'(edge_pulse[0]), 32'h0);
        step();
        chk("filt_pulse_at6", 32'(edge_pulse[0]), 32'h1);
        steps(12);
        clr = 8'hFF; step(); clr = '0; step();

        // Mode selectivity: ch1 rise, ch2 fall, ch3 off
        filt_len = '0;
        mode = {8{MODE_BOTH}};
        mode[3:2] = MODE_RISE; mode[5:4] = MODE_FALL; mode[7:6] = MODE_OFF;
        pulse_acc = '0;
        data_in[3:1] = 3'b111; steps(10);
        chk("mode_rise_ch1", 32'(pulse_acc[1]), 32'h1);
        chk("mode_rise_ch2", 32'(pulse_acc[2]), 32'h0);
        chk("mode_rise_ch3", 32'(pulse_acc[3]), 32'h0);
        chk("mode_rise_level", 32'(level_out[3:1]), 32'h7);
        pulse_acc = '0;
        data_in[3:1] = 3'b000; steps(10);
        chk("mode_fall_ch1", 32'(pulse_acc[1]), 32'h0);
        chk("mode_fall_ch2", 32'(pulse_acc[2]), 32'h1);
        chk("mode_fall_ch3", 32'(pulse_acc[3]), 32'h0);
        chk("mode_fall_level", 32'(level_out[3:1]), 32'h0);
        clr = 8'hFF; step(); clr = '0; step();

        // Clear colliding with a new pulse: set wins; clear alone then drops it
        mode = {8{MODE_BOTH}};
        data_in[4] = 1'b1; steps(5);
        chk("coll_pending_pre", 32'(pending[4]), 32'h1);
        data_in[4] = 1'b0; steps(3);
        chk("coll_pulse", 32'(edge_pulse[4]), 32'h1);
        clr[4] = 1'b1; step();
        chk("coll_set_wins", 32'(pending[4]), 32'h1);
        step();
        chk("clr_alone", 32'(pending[4]), 32'h0);
        chk("clr_alone_irq", 32'(irq), 32'h0);
        clr = '0; step();

        // Async reset in the middle of a filter count
        filt_len = 4'd8; pulse_acc = '0;
        data_in[0] = 1'b1; steps(6);
        resetn = 1'b0; data_in = '0;
        model_reset();
        #1;
        chk("midrst_level", 32'(level_out), 32'h0);
        chk("midrst_pulse", 32'(edge_pulse), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        steps(2);
        resetn = 1'b1;
        steps(20);
        chk("midrst_no_pulse", 32'(pulse_acc), 32'h0);
        chk("midrst_level_low", 32'(level_out), 32'h0);

        // Simultaneous edges on several channels
        filt_len = '0;
        data_in = 8'hA5; steps(2);
        chk("simul_no_early", 32'(edge_pulse), 32'h0);
        step();
        chk("simul_pulse", 32'(edge_pulse), 32'hA5);
        step();
        chk("simul_pulse_gone", 32'(edge_pulse), 32'h0);
        chk("simul_pending", 32'(pending), 32'hA5);
        chk("simul_irq", 32'(irq), 32'h1);

        // Randomised traffic checked against the model every cycle
        for (int seg = 0; seg < 40; seg++) begin
            filt_len = 4'($urandom_range(0, 4));
            mode = 16'($urandom);
            if (seg == 20) begin
                resetn = 1'b0;
                model_reset();
                step();
                resetn = 1'b1;
            end
            for (int i = 0; i < 15; i++) begin
                data_in = data_in ^ 8'($urandom & $urandom);
                clr = 8'($urandom & $urandom & $urandom);
                step();
            end
        end
        clr = '0;
        steps(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
